// File: rtl/div_pkg.sv
// Shared definitions for the divider result path: special constants, flag layout
// and the result classifier reused by the divider bench.
package div_pkg;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    localparam int FLG_NAN = 3;
    localparam int FLG_INF = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
    } div_res_t;

    // First matching rule wins; specials outrank exponent saturation.
    function automatic div_res_t div_classify(
        input logic [30:0] mag,
        input logic        sign,
        input logic        nan,
        input logic        num_inf,
        input logic        num_zero,
        input logic        den_inf,
        input logic        den_zero
    );
        div_res_t res;
        res.result = {sign, mag};
        res.flags  = 4'b0000;
        if (nan) begin
            res.result         = QNAN;
            res.flags[FLG_NAN] = 1'b1;
        end else if (num_inf || den_zero) begin
            res.result         = {sign, EXP_MAX, 23'h00_0000};
            res.flags[FLG_INF] = 1'b1;
        end else if (num_zero || den_inf) begin
            res.result = {sign, 31'h0000_0000};
        end else if (mag[30:23] == EXP_MAX) begin
            res.result         = {sign, EXP_MAX, 23'h00_0000};
            res.flags[FLG_INF] = 1'b1;
            res.flags[FLG_OVF] = 1'b1;
        end else if ((mag[30:23] == 8'h00) && (mag[22:0] != 23'h00_0000)) begin
            res.result         = {sign, 31'h0000_0000};
            res.flags[FLG_UNF] = 1'b1;
        end else begin
            res.result = {sign, mag};
        end
        return res;
    endfunction

endpackage

// File: rtl/div_res_fifo.sv
// Synchronous FIFO with a registered head: rd_data/rd_valid are flops that already
// hold the next entry on the same edge that pushes into an empty FIFO or pops.
module div_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]    CNT_0   = (AW+1)'(0);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;

    logic             push_s;
    logic             pop_s;
    logic [AW:0]      count_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;

    assign full     = (count_r == CNT_MAX);
    assign push_s   = wr_en & ~full;
    assign pop_s    = rd_en & valid_r;
    assign rd_valid = valid_r;
    assign rd_data  = head_r;

    // Next occupancy, read pointer and head value.
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = head_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // The incoming word becomes head when nothing older remains stored.
        if (count_nxt_s == CNT_0) begin
            head_nxt_s = head_r;
        end else if ((count_r == CNT_0) || (pop_s && (count_r == CNT_ONE))) begin
            head_nxt_s = wr_data;
        end else if (pop_s) begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage array; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= (count_nxt_s != CNT_0);
        end
    end

endmodule

// File: rtl/div_result_pack.sv
// Divider output stage: classifies each quotient into an IEEE-754 single result
// plus flags and queues it behind a valid/ready port; records dropped inputs.
module div_result_pack
    import div_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mag,
    input  logic        in_sign,
    input  logic        in_nan,
    input  logic        in_num_inf,
    input  logic        in_num_zero,
    input  logic        in_den_inf,
    input  logic        in_den_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic        drop_err
);

    div_res_t class_s;
    div_res_t head_s;
    logic     full_s;
    logic     push_s;
    logic     drop_err_r;
    logic     unused_s;

    assign class_s  = div_classify(in_mag[30:0], in_sign, in_nan, in_num_inf,
                                   in_num_zero, in_den_inf, in_den_zero);
    assign in_ready = ~full_s;
    assign push_s   = in_valid & ~full_s;
    assign unused_s = in_mag[31];

    div_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .clk      (clk),
        .rstb     (rstb),
        .wr_en    (push_s),
        .wr_data  (class_s),
        .full     (full_s),
        .rd_en    (out_ready),
        .rd_valid (out_valid),
        .rd_data  (head_s)
    );

    assign out_result = head_s.result;
    assign out_flags  = head_s.flags;
    assign drop_err   = drop_err_r;

    // Sticky record of any input offered while the FIFO was full.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            drop_err_r <= 1'b0;
        end else if (in_valid && full_s) begin
            drop_err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_result_pack.sv
// Scoreboard bench for div_result_pack: directed vectors with hand-computed results.
module tb_div_result_pack;

    logic        clk = 1'b0;
    logic        rstb;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mag;
    logic        in_sign;
    logic        in_nan;
    logic        in_num_inf;
    logic        in_num_zero;
    logic        in_den_inf;
    logic        in_den_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        drop_err;

    logic [35:0] exp_q[$];
    logic [35:0] mon_e;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    div_result_pack #(.DEPTH(4)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mag      (in_mag),
        .in_sign     (in_sign),
        .in_nan      (in_nan),
        .in_num_inf  (in_num_inf),
        .in_num_zero (in_num_zero),
        .in_den_inf  (in_den_inf),
        .in_den_zero (in_den_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .drop_err    (drop_err)
    );

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // sp = {nan, num_inf, num_zero, den_inf, den_zero}; called just after a rising edge
    task automatic send(input logic [31:0] mag, input logic sign, input logic [4:0] sp,
                        input logic [31:0] er, input logic [3:0] ef, input logic accept);
        chk("in_ready", {35'h0, in_ready}, {35'h0, accept});
        in_mag      = mag;
        in_sign     = sign;
        {in_nan, in_num_inf, in_num_zero, in_den_inf, in_den_zero} = sp;
        in_valid    = 1'b1;
        if (accept) exp_q.push_back({er, ef});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        {in_nan, in_num_inf, in_num_zero, in_den_inf, in_den_zero} = 5'b00000;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 36'(exp_q.size()), 36'h0);
        chk("drain_out_valid", {35'h0, out_valid}, 36'h0);
    endtask

    // Monitor: compare whatever the consumer accepts against the scoreboard head.
    always @(negedge clk) begin
        if (rstb && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", {out_result, out_flags});
            end else begin
                mon_e = exp_q.pop_front();
                chk("scoreboard", {out_result, out_flags}, mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] m;
        rstb = 1'b0;
        in_valid = 1'b0;
        in_mag = 32'h0;
        in_sign = 1'b0;
        {in_nan, in_num_inf, in_num_zero, in_den_inf, in_den_zero} = 5'b00000;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", {35'h0, out_valid}, 36'h0);
        chk("rst_in_ready", {35'h0, in_ready}, 36'h1);
        chk("rst_out", {out_result, out_flags}, 36'h0);
        chk("rst_drop_err", {35'h0, drop_err}, 36'h0);
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // Normal result with one-cycle latency
        send(32'h3FC0_0000, 1'b1, 5'b00000, 32'hBFC0_0000, 4'b0000, 1'b1);
        chk("latency_valid", {35'h0, out_valid}, 36'h1);
        chk("latency_data", {out_result, out_flags}, {32'hBFC0_0000, 4'b0000});
        // Priorities and saturation
        send(32'h3F80_0000, 1'b1, 5'b10001, 32'h7FC0_0000, 4'b1000, 1'b1);
        send(32'h3F80_0000, 1'b0, 5'b00001, 32'h7F80_0000, 4'b0100, 1'b1);
        send(32'h7F80_1234, 1'b0, 5'b00000, 32'h7F80_0000, 4'b0110, 1'b1);
        send(32'h0000_0400, 1'b1, 5'b00000, 32'h8000_0000, 4'b0001, 1'b1);
        send(32'h4000_0000, 1'b1, 5'b01000, 32'hFF80_0000, 4'b0100, 1'b1);
        send(32'h4000_0000, 1'b1, 5'b00100, 32'h8000_0000, 4'b0000, 1'b1);
        send(32'h4000_0000, 1'b0, 5'b00010, 32'h0000_0000, 4'b0000, 1'b1);
        send(32'hC000_0000, 1'b0, 5'b00000, 32'h4000_0000, 4'b0000, 1'b1);
        send(32'h0000_0000, 1'b1, 5'b00000, 32'h8000_0000, 4'b0000, 1'b1);
        wait_drain();

        // Fill and drop with the consumer stalled
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h3F80_0000, 1'b0, 5'b00000, 32'h3F80_0000, 4'b0000, 1'b1);
        send(32'h4000_0000, 1'b0, 5'b00000, 32'h4000_0000, 4'b0000, 1'b1);
        send(32'h4040_0000, 1'b1, 5'b00000, 32'hC040_0000, 4'b0000, 1'b1);
        send(32'h4080_0000, 1'b0, 5'b00000, 32'h4080_0000, 4'b0000, 1'b1);
        send(32'h40A0_0000, 1'b0, 5'b00000, 32'h40A0_0000, 4'b0000, 1'b0);
        chk("drop_err_set", {35'h0, drop_err}, 36'h1);
        chk("stall_head", {out_result, out_flags, out_valid}, 37'({32'h3F80_0000, 4'b0000, 1'b1}));
        out_ready = 1'b1;
        wait_drain();
        chk("drop_err_sticky", {35'h0, drop_err}, 36'h1);

        // Two queued entries, then push and pop every cycle
        out_ready = 1'b0;
        send(32'h4100_0000, 1'b0, 5'b00000, 32'h4100_0000, 4'b0000, 1'b1);
        send(32'h4110_0000, 1'b1, 5'b00000, 32'hC110_0000, 4'b0000, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            m = {1'b0, 8'(8'h40 + i), 23'(i * 3 + 1)};
            send(m, 1'(i), 5'b00000, {1'(i), m[30:0]}, 4'b0000, 1'b1);
            chk("steady_valid", {35'h0, out_valid}, 36'h1);
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("steady_ready_2left", {35'h0, in_ready}, 36'h1);
        out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a burst
        out_ready = 1'b0;
        send(32'h4200_0000, 1'b0, 5'b00000, 32'h4200_0000, 4'b0000, 1'b1);
        send(32'h4210_0000, 1'b0, 5'b00000, 32'h4210_0000, 4'b0000, 1'b1);
        send(32'h4220_0000, 1'b0, 5'b00000, 32'h4220_0000, 4'b0000, 1'b1);
        rstb = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", {35'h0, out_valid}, 36'h0);
        chk("mid_rst_in_ready", {35'h0, in_ready}, 36'h1);
        chk("mid_rst_out", {out_result, out_flags}, 36'h0);
        chk("mid_rst_drop_err", {35'h0, drop_err}, 36'h0);
        #20;
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h4300_0000, 1'b1, 5'b00000, 32'hC300_0000, 4'b0000, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_result_pack.md
# div_result_pack

Output stage placed directly downstream of the Goldschmidt sequential divider. It captures each finished quotient magnitude together with the operand sign and special-case flags recorded when the request was issued. It applies sign, special-value overrides and exponent overflow/underflow saturation, then buffers the IEEE-754 single-precision results in a small FIFO behind a valid/ready output port.

## Interface
- DEPTH, 4, result FIFO entries; power of two, at least 2.
- clk  in  1  clock; all state updates on rising edge.
- rstb  in  1  asynchronous active-low reset.
- in_valid  in  1  one-cycle strobe: divider result and flags are valid this cycle.
- in_ready  out  1  FIFO can accept an entry; the divider issues no new req while low.
- in_mag  in  32  divider quotient; bit 31 is ignored.
- in_sign  in  1  numerator[31] XOR denominator[31], latched at request time.
- in_nan  in  1  divider NaN flag.
- in_num_inf  in  1  numerator is ±infinity.
- in_num_zero  in  1  numerator is ±zero.
- in_den_inf  in  1  denominator is ±infinity.
- in_den_zero  in  1  denominator is ±zero.
- out_valid  out  1  out_result and out_flags hold the FIFO head.
- out_ready  in  1  consumer accepts the head this cycle.
- out_result  out  32  packed IEEE-754 single-precision quotient.
- out_flags  out  4  {nan, inf, ovf, unf} for the head entry.
- drop_err  out  1  sticky flag: an input was dropped because the FIFO was full.

## Operation
- Classification is combinational on the in_* signals. The first matching rule applies:
  - in_nan: result 32'h7FC0_0000 (canonical NaN), flags nan.
  - in_num_inf or in_den_zero: result {in_sign, 8'hFF, 23'h0}, flags inf.
  - in_num_zero or in_den_inf: result {in_sign, 31'h0}, no flags.
  - in_mag[30:23] == 8'hFF: result {in_sign, 8'hFF, 23'h0}, flags inf and ovf.
  - in_mag[30:23] == 8'h00 with nonzero mantissa: flush to {in_sign, 31'h0}, flags unf.
  - Otherwise: result {in_sign, in_mag[30:0]}, no flags.
- Push: in_valid && in_ready writes {result, flags} at the write pointer.
- Pop: out_valid && out_ready advances the read pointer.
- Pointers are log2(DEPTH) bits and wrap naturally. The occupancy counter is log2(DEPTH)+1 bits.
- in_ready = (count != DEPTH). It is registered-state derived; there is no combinational path from out_ready.
- in_valid while full: the input is dropped, drop_err is set, and FIFO state is unchanged. This holds even if a pop happens in the same cycle.
- Push and pop in the same cycle when not full: count is unchanged and both pointers advance.
- drop_err clears only on reset.
- out_result and out_flags are registered copies of the head entry. They update on the edge that changes the head, and hold their value while out_valid is low.

## Timing
- Reset values: out_valid 0, out_result 0, out_flags 0, in_ready 1, drop_err 0, pointers 0, count 0.
- Latency: in_valid sampled at edge N into an empty FIFO gives out_valid=1 with that result after edge N. It is visible in cycle N+1.
- Throughput: one push and one pop per cycle.
- Back-to-back in_valid is legal even though the divider normally produces at most one result every 7 cycles.
- Holding out_ready low: the head and out_valid stay stable. The FIFO fills, then in_ready drops.
- Reset asserted mid-operation: all entries are discarded immediately, with no output glitch beyond returning to reset values.

## Structure
- Shared package div_pkg holds:
  - constants QNAN = 32'h7FC0_0000, EXP_MAX = 8'hFF;
  - flag bit indices FLG_NAN, FLG_INF, FLG_OVF, FLG_UNF.
- Classifier is a combinational function in div_pkg so the divider bench can reuse it.
- One sub-module: div_res_fifo (generic DEPTH x 36 synchronous FIFO with registered head output). The top level contains classification and drop_err only.

## Test plan
- Normal result: in_mag 32'h3FC0_0000, in_sign 1, out_ready 1 -> out_result 32'hBFC0_0000 one cycle later, flags 0.
- Special priority: in_nan=1 together with in_den_zero=1 -> 32'h7FC0_0000 with flags nan only. Then in_den_zero=1, in_sign=0 -> 32'h7F80_0000 with flags inf.
- Saturation: in_mag 32'h7F80_1234 -> 32'h7F80_0000 with inf and ovf. in_mag 32'h0000_0400, sign 1 -> 32'h8000_0000 with unf.
- Fill and drop: out_ready 0, 5 pushes with DEPTH 4 -> in_ready low after the 4th push, 5th push dropped, drop_err 1. Drain -> the 4 results emerge in order and drop_err stays 1.
- Simultaneous traffic: FIFO holding 2 entries, push and pop every cycle for 10 cycles -> count stays 2, order preserved, pointers wrap without loss.
- Reset mid-burst: rstb low with 3 entries queued -> out_valid 0 and in_ready 1 immediately. After release, a new push is output first.
